envelope_slope_arbiter: RTL and testbench
=========================================

ENVELOPE_SLOPE_ARBITER -- requirements
Module: envelope_slope_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_VOICES, default 4, number of envelope requesters; WIDTH, default 32, operand and slope width; TIMEOUT, default 64, maximum Env_ce cycles to wait for Calc_done.
REQ-002 Sys_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Env_rst  in  1  asynchronous, active-high reset.
REQ-004 Env_ce  in  1  clock enable; state advances only on edges where Env_ce=1.
REQ-005 Req  in  NUM_VOICES  level request per voice; held until that voice's Ack.
REQ-006 Rise_bus  in  NUM_VOICES*WIDTH  signed rise per voice; voice v occupies bits [v*WIDTH +: WIDTH].
REQ-007 Run_bus  in  NUM_VOICES*WIDTH  unsigned run per voice, same packing as Rise_bus.
REQ-008 Ack  out  NUM_VOICES  one-hot, one-cycle pulse marking Slope valid for that voice.
REQ-009 Slope  out  WIDTH  result for the acked voice; holds until the next delivery.
REQ-010 Slope_voice  out  clog2(NUM_VOICES)  index of the voice the current Slope belongs to.
REQ-011 Err  out  1  high with Ack when the delivered slope is a timeout result.
REQ-012 Busy  out  1  high in every state except IDLE.
REQ-013 Calc_start  out  1  one-cycle start pulse to the shared Slope_Calc.
REQ-014 Calc_rise / Calc_run  out  WIDTH each  operands latched for the divider; stable from Calc_start until completion.
REQ-015 Calc_done  in  1  divider completion pulse.
REQ-016 Calc_slope  in  WIDTH  divider result, valid with Calc_done.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT and DELIVER.
REQ-018 IDLE SHALL pick a voice when any Req bit is high, using round-robin priority starting at (last granted + 1) mod NUM_VOICES; after reset the search starts at voice 0.
REQ-019 On a grant, the block SHALL latch that voice's Rise and Run into Calc_rise/Calc_run and record the voice index.
REQ-020 If the latched Run is nonzero, the FSM SHALL go IDLE->ISSUE, assert Calc_start for exactly one cycle in ISSUE, then go to WAIT.
REQ-021 If the latched Run is 0, the divider SHALL be bypassed: IDLE->DELIVER with result = Rise and no Calc_start.
REQ-022 In WAIT, a Calc_done sampled with Env_ce=1 SHALL capture Calc_slope and move to DELIVER.
REQ-023 The WAIT timeout counter SHALL start at 0 and count Env_ce cycles; reaching TIMEOUT without Calc_done SHALL force result = 0, set Err for the delivery, and move to DELIVER.
REQ-024 DELIVER SHALL last one cycle: it updates Slope/Slope_voice, pulses Ack for the granted voice (plus Err if applicable), records that voice as last granted, and returns to IDLE.
REQ-025 Throughput SHALL be at most one grant per voice per arbitration round; two voices requesting continuously SHALL alternate.
REQ-026 Latency from grant to Ack SHALL be 2 cycles plus the divider latency; a bypass grant SHALL reach Ack 1 cycle after grant.
REQ-027 If a granted voice drops Req mid-operation, the operation SHALL still complete and Ack that voice.
REQ-028 Calc_done arriving outside WAIT SHALL be ignored.
REQ-029 With Env_ce=0, all state SHALL freeze and Ack and Calc_start SHALL be forced to 0; a pending pulse fires on the first cycle with Env_ce=1.
REQ-030 Simultaneous requests SHALL be served in round-robin order only; no request is lost while it stays asserted.

Reset
REQ-031 Env_rst high SHALL immediately force: FSM to IDLE; Ack, Calc_start, Err and Busy to 0; Slope, Calc_rise and Calc_run to 0; Slope_voice to 0; last-granted pointer to NUM_VOICES-1; timeout counter to 0.
REQ-032 Reset during WAIT SHALL abandon the operation without an Ack; a subsequent stale Calc_done SHALL be ignored.

Verification
REQ-033 Voice 0 requests Rise=0x7FFF_0000, Run=0x0000_03E8; the divider model returns rise/run after 10 cycles -> Calc_start once, Ack[0] pulses with Slope=0x0020_C45A, Err=0.
REQ-034 Voices 1 and 2 request together with Run=0x0000_07D0 -> voice 1 acked first and then voice 2, each with Slope=0x0010_622D; round-robin order is maintained over 4 rounds.
REQ-035 Voice 3 requests with Run=0 and Rise=0x1234_5678 -> no Calc_start, Ack[3] 2 cycles after Req, Slope=0x1234_5678.
REQ-036 Divider model never asserts Calc_done -> after TIMEOUT cycles, Ack with Err=1 and Slope=0; the next request is served normally.
REQ-037 Env_ce held low for 100 cycles during WAIT, and Env_rst pulsed during WAIT -> the state freezes with no pulses; the reset returns the block to IDLE and a late Calc_done produces no Ack.

Source files
------------

// File: rtl/envelope_slope_arbiter.sv
// rtl/envelope_slope_arbiter.sv - round-robin arbiter sharing one slope divider between envelope voices
// Grants one voice at a time, runs rise/run through the divider (or bypasses on run=0), and acks the result.

module envelope_slope_arbiter #(
    parameter  int NUM_VOICES = 4,
    parameter  int WIDTH      = 32,
    parameter  int TIMEOUT    = 64,
    localparam int VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                        Sys_clk,
    input  logic                        Env_rst,
    input  logic                        Env_ce,
    input  logic [NUM_VOICES-1:0]       Req,
    input  logic [NUM_VOICES*WIDTH-1:0] Rise_bus,
    input  logic [NUM_VOICES*WIDTH-1:0] Run_bus,
    output logic [NUM_VOICES-1:0]       Ack,
    output logic [WIDTH-1:0]            Slope,
    output logic [VW-1:0]               Slope_voice,
    output logic                        Err,
    output logic                        Busy,
    output logic                        Calc_start,
    output logic [WIDTH-1:0]            Calc_rise,
    output logic [WIDTH-1:0]            Calc_run,
    input  logic                        Calc_done,
    input  logic [WIDTH-1:0]            Calc_slope
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [VW-1:0]          r_last;
    logic [VW-1:0]          r_voice;
    logic [VW-1:0]          r_slope_voice;
    logic [VW-1:0]          w_gnt_idx;
    logic [VW-1:0]          w_cand [NUM_VOICES];
    logic [NUM_VOICES-1:0]  r_ack;
    logic [NUM_VOICES-1:0]  w_req_eff;
    logic [NUM_VOICES-1:0]  w_voice_hot;
    logic                   w_gnt_valid;
    logic                   w_timeout;
    logic                   r_err;
    logic                   r_err_pend;
    logic [WIDTH-1:0]       r_calc_rise;
    logic [WIDTH-1:0]       r_calc_run;
    logic [WIDTH-1:0]       r_result;
    logic [WIDTH-1:0]       r_slope;
    logic [WIDTH-1:0]       w_sel_rise;
    logic [WIDTH-1:0]       w_sel_run;
    logic [CW-1:0]          r_cnt;

    // The voice being acked this cycle still has Req high; masking it stops a double grant.
    assign w_req_eff = Req & ~r_ack;

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_cand[i] = VW'((int'(r_last) + 1 + i) % NUM_VOICES);
        end
    end

    // Walk candidates from farthest to nearest so the nearest requester after r_last wins.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (w_req_eff[w_cand[i]]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = w_cand[i];
            end
        end
    end

    always_comb begin
        w_sel_rise  = '0;
        w_sel_run   = '0;
        w_voice_hot = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (w_gnt_idx == VW'(i)) begin
                w_sel_rise = Rise_bus[i*WIDTH +: WIDTH];
                w_sel_run  = Run_bus[i*WIDTH +: WIDTH];
            end
            w_voice_hot[i] = (r_voice == VW'(i));
        end
    end

    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge Sys_clk or posedge Env_rst) begin
        if (Env_rst) begin
            r_state <= S_IDLE;
        end else if (Env_ce) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_valid) begin
                    w_next = (w_sel_run != '0) ? S_ISSUE : S_DELIVER;
                end
            end
            S_ISSUE:   w_next = S_WAIT;
            S_WAIT: begin
                if (Calc_done || w_timeout) begin
                    w_next = S_DELIVER;
                end
            end
            S_DELIVER: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Sys_clk or posedge Env_rst) begin
        if (Env_rst) begin
            r_last        <= VW'(NUM_VOICES - 1);
            r_voice       <= '0;
            r_slope_voice <= '0;
            r_ack         <= '0;
            r_err         <= 1'b0;
            r_err_pend    <= 1'b0;
            r_calc_rise   <= '0;
            r_calc_run    <= '0;
            r_result      <= '0;
            r_slope       <= '0;
            r_cnt         <= '0;
        end else if (Env_ce) begin
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_valid) begin
                        // Result defaults to rise so the run=0 bypass needs no extra path.
                        r_voice     <= w_gnt_idx;
                        r_calc_rise <= w_sel_rise;
                        r_calc_run  <= w_sel_run;
                        r_result    <= w_sel_rise;
                        r_cnt       <= '0;
                        r_err_pend  <= 1'b0;
                    end
                end
                S_ISSUE: begin
                end
                S_WAIT: begin
                    if (Calc_done) begin
                        r_result <= Calc_slope;
                    end else if (w_timeout) begin
                        r_result   <= '0;
                        r_err_pend <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DELIVER: begin
                    r_slope       <= r_result;
                    r_slope_voice <= r_voice;
                    r_ack         <= w_voice_hot;
                    r_err         <= r_err_pend;
                    r_last        <= r_voice;
                end
                default: begin
                end
            endcase
        end
    end

    // Pulses are held in their registers while Env_ce is low and fire once it returns.
    assign Ack         = r_ack & {NUM_VOICES{Env_ce}};
    assign Err         = r_err & Env_ce;
    assign Calc_start  = (r_state == S_ISSUE) & Env_ce;
    assign Busy        = (r_state != S_IDLE);
    assign Slope       = r_slope;
    assign Slope_voice = r_slope_voice;
    assign Calc_rise   = r_calc_rise;
    assign Calc_run    = r_calc_run;

endmodule

// File: tb/tb_envelope_slope_arbiter.sv
// tb/tb_envelope_slope_arbiter.sv - self-checking bench for envelope_slope_arbiter
// Scenario tasks plus randomized traffic against a behavioural divider and round-robin model.

module tb_envelope_slope_arbiter;

    localparam int NV = 4;
    localparam int W  = 32;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ce  = 1'b1;
    logic [NV-1:0]   req = '0;
    logic [NV*W-1:0] rise_bus = '0;
    logic [NV*W-1:0] run_bus  = '0;
    logic [NV-1:0]   ack;
    logic [W-1:0]    slope;
    logic [1:0]      slope_voice;
    logic            err;
    logic            busy;
    logic            calc_start;
    logic [W-1:0]    calc_rise;
    logic [W-1:0]    calc_run;
    logic            calc_done  = 1'b0;
    logic [W-1:0]    calc_slope = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_starts = 0;
    int n_acks = 0;
    int model_last = NV - 1;
    bit div_on = 1'b1;
    bit div_rand = 1'b0;
    int div_lat = 10;

    envelope_slope_arbiter #(.NUM_VOICES(NV), .WIDTH(W), .TIMEOUT(TO)) dut (
        .Sys_clk(clk), .Env_rst(rst), .Env_ce(ce), .Req(req),
        .Rise_bus(rise_bus), .Run_bus(run_bus), .Ack(ack), .Slope(slope),
        .Slope_voice(slope_voice), .Err(err), .Busy(busy), .Calc_start(calc_start),
        .Calc_rise(calc_rise), .Calc_run(calc_run), .Calc_done(calc_done),
        .Calc_slope(calc_slope)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (calc_start) n_starts++;
        if (ack != '0) n_acks++;
    end

    function automatic logic [W-1:0] quot(input logic [W-1:0] r, input logic [W-1:0] d);
        longint q;
        if (d == '0) return r;
        q = longint'($signed(r)) / longint'({32'b0, d});
        return q[W-1:0];
    endfunction

    // Behavioural divider: answers rise/run a fixed or random number of cycles after a start.
    initial begin
        forever begin
            @(negedge clk);
            if (calc_start && div_on && !rst) begin
                automatic logic [W-1:0] a = calc_rise;
                automatic logic [W-1:0] b = calc_run;
                automatic int lat = div_rand ? int'($urandom_range(1, 8)) : div_lat;
                @(posedge clk);
                repeat (lat - 1) @(posedge clk);
                #1;
                calc_slope = quot(a, b);
                calc_done  = 1'b1;
                @(posedge clk);
                #1;
                calc_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic set_voice(input int v, input logic [W-1:0] r, input logic [W-1:0] d);
        rise_bus[v*W +: W] = r;
        run_bus[v*W +: W]  = d;
    endtask

    task automatic wait_ack(input int budget, output int cyc, output logic [NV-1:0] a);
        cyc = 0;
        a   = '0;
        while (cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ack != '0) begin
                a = ack;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_cmp++; if (ack !== '0) begin n_bad++; $display("FAIL reset_ack: got %b expected 0", ack); end
        n_cmp++; if (calc_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b expected 0", calc_start); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (slope !== '0) begin n_bad++; $display("FAIL reset_slope: got %h expected 0", slope); end
        n_cmp++; if (slope_voice !== 2'd0) begin n_bad++; $display("FAIL reset_voice: got %0d expected 0", slope_voice); end
        n_cmp++; if ({calc_rise, calc_run} !== '0) begin n_bad++; $display("FAIL reset_operands: got %h/%h expected 0", calc_rise, calc_run); end
        @(negedge clk);
        rst = 1'b0;
        model_last = NV - 1;
    endtask

    task automatic test_single_divide();
        int cyc; logic [NV-1:0] a; int s0;
        div_on = 1'b1; div_rand = 1'b0; div_lat = 10;
        set_voice(0, 32'h7FFF_0000, 32'h0000_03E8);
        @(posedge clk); #1;
        s0 = n_starts;
        req[0] = 1'b1;
        wait_ack(100, cyc, a);
        n_cmp++; if (a !== 4'b0001) begin n_bad++; $display("FAIL single_ack: got %b expected 0001", a); end
        n_cmp++; if (slope !== 32'h0020_C45A) begin n_bad++; $display("FAIL single_slope: got %h expected 0020c45a", slope); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b expected 0", err); end
        n_cmp++; if (cyc !== 13) begin n_bad++; $display("FAIL single_latency: got %0d expected 13", cyc); end
        n_cmp++; if (n_starts - s0 !== 1) begin n_bad++; $display("FAIL single_starts: got %0d expected 1", n_starts - s0); end
        req[0] = 1'b0;
        model_last = 0;
        @(posedge clk); #1;
        n_cmp++; if (ack !== '0) begin n_bad++; $display("FAIL single_pulse_width: got %b expected 0", ack); end
    endtask

    task automatic test_round_robin();
        int cyc; logic [NV-1:0] a; int exp_v;
        div_lat = 3;
        set_voice(1, 32'h7FFF_0000, 32'h0000_07D0);
        set_voice(2, 32'h7FFF_0000, 32'h0000_07D0);
        req = 4'b0110;
        for (int r = 0; r < 8; r++) begin
            exp_v = -1;
            for (int k = 1; k <= NV; k++) begin
                if (exp_v < 0 && req[(model_last + k) % NV]) exp_v = (model_last + k) % NV;
            end
            wait_ack(50, cyc, a);
            n_cmp++; if (a !== (4'b0001 << exp_v)) begin n_bad++; $display("FAIL rr_order[%0d]: got %b expected voice %0d", r, a, exp_v); end
            n_cmp++; if (slope !== 32'h0010_622D) begin n_bad++; $display("FAIL rr_slope[%0d]: got %h expected 0010622d", r, slope); end
            model_last = exp_v;
        end
        req = '0;
    endtask

    task automatic test_bypass();
        int cyc; logic [NV-1:0] a; int s0;
        set_voice(3, 32'h1234_5678, 32'h0);
        @(posedge clk); #1;
        s0 = n_starts;
        req[3] = 1'b1;
        wait_ack(20, cyc, a);
        n_cmp++; if (a !== 4'b1000) begin n_bad++; $display("FAIL bypass_ack: got %b expected 1000", a); end
        n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL bypass_latency: got %0d expected 2", cyc); end
        n_cmp++; if (slope !== 32'h1234_5678) begin n_bad++; $display("FAIL bypass_slope: got %h expected 12345678", slope); end
        n_cmp++; if (slope_voice !== 2'd3) begin n_bad++; $display("FAIL bypass_voice: got %0d expected 3", slope_voice); end
        n_cmp++; if (n_starts !== s0) begin n_bad++; $display("FAIL bypass_nostart: got %0d expected %0d", n_starts, s0); end
        req[3] = 1'b0;
        model_last = 3;
    endtask

    task automatic test_timeout();
        int cyc; logic [NV-1:0] a;
        div_on = 1'b0;
        set_voice(0, 32'd100, 32'd5);
        @(posedge clk); #1;
        req[0] = 1'b1;
        wait_ack(200, cyc, a);
        n_cmp++; if (a !== 4'b0001) begin n_bad++; $display("FAIL timeout_ack: got %b expected 0001", a); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b expected 1", err); end
        n_cmp++; if (slope !== '0) begin n_bad++; $display("FAIL timeout_slope: got %h expected 0", slope); end
        n_cmp++; if (cyc !== TO + 3) begin n_bad++; $display("FAIL timeout_latency: got %0d expected %0d", cyc, TO + 3); end
        req[0] = 1'b0;
        div_on = 1'b1;
        div_lat = 5;
        set_voice(1, -32'sd700, 32'd7);
        @(posedge clk); #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL timeout_err_width: got %b expected 0", err); end
        req[1] = 1'b1;
        wait_ack(50, cyc, a);
        n_cmp++; if (a !== 4'b0010) begin n_bad++; $display("FAIL after_timeout_ack: got %b expected 0010", a); end
        n_cmp++; if (slope !== 32'hFFFF_FF9C) begin n_bad++; $display("FAIL after_timeout_slope: got %h expected ffffff9c", slope); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL after_timeout_err: got %b expected 0", err); end
        req[1] = 1'b0;
        model_last = 1;
    endtask

    task automatic test_ce_gating();
        int cyc; logic [NV-1:0] a; int s0; int a0;
        div_lat = 4;
        set_voice(2, 32'd9000, 32'd30);
        @(posedge clk); #1;
        req[2] = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0;
        s0 = n_starts;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (n_starts !== s0) begin n_bad++; $display("FAIL ce_start_gated: got %0d starts expected %0d", n_starts, s0); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ce_busy: got %b expected 1", busy); end
        ce = 1'b1;
        #1;
        n_cmp++; if (calc_start !== 1'b1) begin n_bad++; $display("FAIL ce_start_resume: got %b expected 1", calc_start); end
        wait_ack(50, cyc, a);
        n_cmp++; if (a !== 4'b0100) begin n_bad++; $display("FAIL ce_div_ack: got %b expected 0100", a); end
        n_cmp++; if (slope !== 32'd300) begin n_bad++; $display("FAIL ce_div_slope: got %h expected 0000012c", slope); end
        req[2] = 1'b0;
        set_voice(3, 32'hCAFE_0001, 32'h0);
        @(posedge clk); #1;
        req[3] = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0;
        a0 = n_acks;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (n_acks !== a0) begin n_bad++; $display("FAIL ce_ack_gated: got %0d acks expected %0d", n_acks, a0); end
        ce = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ack !== 4'b1000) begin n_bad++; $display("FAIL ce_ack_resume: got %b expected 1000", ack); end
        n_cmp++; if (slope !== 32'hCAFE_0001) begin n_bad++; $display("FAIL ce_bypass_slope: got %h expected cafe0001", slope); end
        req[3] = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (ack !== '0) begin n_bad++; $display("FAIL ce_ack_once: got %b expected 0", ack); end
        model_last = 3;
    endtask

    task automatic test_freeze_reset();
        int cyc; logic [NV-1:0] a; int s0; int a0;
        div_on = 1'b0;
        set_voice(1, 32'd600, 32'd3);
        @(posedge clk); #1;
        req[1] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        ce = 1'b0;
        s0 = n_starts;
        a0 = n_acks;
        repeat (100) @(posedge clk);
        #1;
        n_cmp++; if (n_acks !== a0) begin n_bad++; $display("FAIL freeze_no_ack: got %0d acks expected %0d", n_acks, a0); end
        n_cmp++; if (n_starts !== s0) begin n_bad++; $display("FAIL freeze_no_start: got %0d expected %0d", n_starts, s0); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL freeze_busy: got %b expected 1", busy); end
        req = '0;
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
        n_cmp++; if (calc_run !== '0) begin n_bad++; $display("FAIL async_reset_run: got %h expected 0", calc_run); end
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b1;
        model_last = NV - 1;
        @(posedge clk); #1;
        calc_slope = 32'hDEAD_BEEF;
        calc_done  = 1'b1;
        @(posedge clk); #1;
        calc_done = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (n_acks !== a0) begin n_bad++; $display("FAIL stale_done_ack: got %0d acks expected %0d", n_acks, a0); end
        n_cmp++; if (slope !== '0) begin n_bad++; $display("FAIL stale_done_slope: got %h expected 0", slope); end
        div_on = 1'b1;
        div_lat = 2;
        set_voice(0, 32'd50, 32'd10);
        set_voice(2, 32'd80, 32'd4);
        req = 4'b0101;
        wait_ack(50, cyc, a);
        n_cmp++; if (a !== 4'b0001) begin n_bad++; $display("FAIL reset_pointer_first: got %b expected 0001", a); end
        n_cmp++; if (slope !== 32'd5) begin n_bad++; $display("FAIL reset_pointer_slope: got %h expected 5", slope); end
        req[0] = 1'b0;
        wait_ack(50, cyc, a);
        n_cmp++; if (a !== 4'b0100) begin n_bad++; $display("FAIL reset_pointer_second: got %b expected 0100", a); end
        n_cmp++; if (slope !== 32'd20) begin n_bad++; $display("FAIL reset_pointer_slope2: got %h expected 14", slope); end
        req[2] = 1'b0;
        model_last = 2;
    endtask

    task automatic test_random();
        logic [W-1:0] rr [NV];
        logic [W-1:0] rn [NV];
        bit   [NV-1:0] pend;
        int waitc [NV];
        int n_ops;
        pend = '0;
        n_ops = 0;
        for (int i = 0; i < NV; i++) begin
            waitc[i] = 0; rr[i] = '0; rn[i] = '0;
        end
        div_on = 1'b1;
        div_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (ack != '0) begin
                int v;
                v = -1;
                for (int i = 0; i < NV; i++) if (ack == (4'b0001 << i)) v = i;
                n_cmp++;
                if (v < 0 || !pend[v]) begin
                    n_bad++; $display("FAIL rand_ack_voice: got %b expected one-hot of pending %b", ack, pend);
                end else begin
                    n_cmp++; if (slope !== quot(rr[v], rn[v])) begin n_bad++; $display("FAIL rand_slope v%0d: got %h expected %h", v, slope, quot(rr[v], rn[v])); end
                    n_cmp++; if (slope_voice !== 2'(v)) begin n_bad++; $display("FAIL rand_slope_voice: got %0d expected %0d", slope_voice, v); end
                    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rand_err v%0d: got %b expected 0", v, err); end
                    n_cmp++; if (waitc[v] > NV - 1) begin n_bad++; $display("FAIL rand_fairness v%0d: got %0d grants to others expected at most %0d", v, waitc[v], NV - 1); end
                    for (int i = 0; i < NV; i++) if (i != v && pend[i]) waitc[i]++;
                    pend[v] = 1'b0;
                    req[v]  = 1'b0;
                    waitc[v] = 0;
                    n_ops++;
                end
            end
            for (int i = 0; i < NV; i++) begin
                if (c < 2400 && !pend[i] && $urandom_range(0, 3) == 0) begin
                    rr[i] = $urandom;
                    rn[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : W'($urandom_range(1, 5000));
                    set_voice(i, rr[i], rn[i]);
                    pend[i] = 1'b1;
                    req[i]  = 1'b1;
                    waitc[i] = 0;
                end
            end
        end
        n_cmp++; if (pend !== '0) begin n_bad++; $display("FAIL rand_drain: got pending %b expected 0000", pend); end
        n_cmp++; if (n_ops < 20) begin n_bad++; $display("FAIL rand_ops: got %0d completed expected at least 20", n_ops); end
        div_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_divide();
        test_round_robin();
        test_bypass();
        test_timeout();
        test_ce_gating();
        test_freeze_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
